// File: rtl/proc_pkg.sv
// Shared opcode constants and fetch FSM state encoding
// for the filter processor.
package proc_pkg;

  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_LD  = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b1101;
  localparam logic [3:0] OP_BT  = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    RST_S  = 2'd0,
    REQ    = 2'd1,
    ISSUE  = 2'd2,
    BUBBLE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC select: taken BT loads the instruction's low
// bits, any other accepted instruction steps PC+1 with wrap.
module next_pc_sel
  import proc_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
) (
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag,
  input  logic               accept,
  output logic [PC_W-1:0]    next_pc
);

  logic is_bt;

  assign is_bt = (instr[INSTR_W-1 -: 4] == OP_BT);

  always_comb begin
    next_pc = pc;
    if (accept) begin
      if (is_bt && flag) next_pc = instr[PC_W-1:0];
      else               next_pc = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue with local BT resolution.
// Optional FETCH_PERF_CNT_EN adds issue/bubble counters.
module instr_fetch_issue
  import proc_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               flag_we,
  input  logic               flag_in,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [3:0]         opcode_out,
  output logic [PC_W-1:0]    pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               flag_q;
  logic               pend_q, pend_d;
  logic               is_bt, is_cmp, accept;

  assign opcode_out = instr_q[INSTR_W-1 -: 4];
  assign is_bt      = (opcode_out == OP_BT);
  assign is_cmp     = (opcode_out == OP_CMP);
  assign instr_out  = instr_q;
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign accept     = instr_valid & ~stall;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      RST_S: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_bt && pend_q) begin
          state_d = BUBBLE;
        end else begin
          instr_valid = 1'b1;
          if (!stall) state_d = REQ;
        end
      end
      BUBBLE: if (!pend_q) state_d = ISSUE;
      default: state_d = RST_S;
    endcase
  end

  // A compare accepted alongside flag_we is a new one.
  always_comb begin
    pend_d = pend_q;
    if (accept && is_cmp) pend_d = 1'b1;
    else if (flag_we)     pend_d = 1'b0;
  end

  next_pc_sel #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q),
    .flag    (flag_q),
    .accept  (accept),
    .next_pc (pc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_S;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      flag_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      if (flag_we) flag_q <= flag_in;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] iss_q, bub_q;

  assign perf_issued  = iss_q;
  assign perf_bubbles = bub_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
      bub_q <= '0;
    end else begin
      if (accept && iss_q != '1) iss_q <= iss_q + 32'd1;
      if (state_q == BUBBLE && bub_q != '1)
        bub_q <= bub_q + 32'd1;
    end
  end
`endif

endmodule
